// File: rtl/cpu_pkg.sv
// Shared widths, limits and the write-port arbiter state encoding.
// No logic; constants and types only.
// Imported by the arbiter top and the register scoreboard.
package cpu_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int XLEN         = 32;
  localparam int NUM_REGS     = 32;
  localparam int STARVE_MAX   = 3;
  localparam int STARVE_CNT_W = 2;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard: marks issued long-latency destinations, clears on LU writeback.
// Latency: busy updates at the next edge; stall is combinational from the current busy state.
// No backpressure of its own; an issue is only recorded when stall is low.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_reg,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_reg,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  stall
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Stall on a RAW hazard against either source, or a WAW against the op being issued.
  // Uses the registered busy state only, so a clear landing this cycle does not release it.
  always_comb begin
    stall = busy[rs1] | busy[rs2] | (set_en & busy[set_reg]);
  end

  // One-hot set/clear masks for this cycle; register 0 is never marked busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_reg != '0) && !stall) begin
      set_mask[set_reg] = 1'b1;
    end
    if (clr_en) begin
      clr_mask[clr_reg] = 1'b1;
    end
  end

  // Busy vector update: clear applied first so a same-bit set wins; bit 0 pinned low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register-file write port between the pipeline and a long-latency unit (LU).
// Latency: the selected write appears on W_en/W_reg/W_data one cycle after acceptance.
// Pipeline has priority; after a starved LU waits long enough it is forced in and the pipeline is held.
module reg_wb_arbiter
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_wen,
  input  logic [REG_ADDR_W-1:0] pipe_wreg,
  input  logic [XLEN-1:0]       pipe_wdata,
  output logic                  pipe_hold,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_wreg,
  input  logic [XLEN-1:0]       lu_wdata,
  output logic                  lu_ready,
  input  logic                  iss_en,
  input  logic [REG_ADDR_W-1:0] iss_reg,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  stall,
  output logic                  W_en,
  output logic [REG_ADDR_W-1:0] W_reg,
  output logic [XLEN-1:0]       W_data
);

  arb_state_t              state;
  arb_state_t              state_nxt;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    pipe_req;
  logic                    pipe_fire;
  logic                    lu_hs;

  // A pipeline write to register 0 is not a request at all.
  assign pipe_req  = pipe_wen && (pipe_wreg != '0);
  assign lu_hs     = lu_valid && lu_ready;
  assign pipe_fire = pipe_req && !pipe_hold;

  // Arbitration state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB_NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs: FORCE lasts exactly one cycle and always admits the LU.
  always_comb begin
    state_nxt = state;
    lu_ready  = !pipe_req;
    pipe_hold = 1'b0;
    case (state)
      ARB_NORMAL: begin
        if ((starve_cnt == STARVE_CNT_W'(STARVE_MAX)) && lu_valid && pipe_req) begin
          state_nxt = ARB_FORCE;
        end
      end
      ARB_FORCE: begin
        lu_ready  = 1'b1;
        pipe_hold = pipe_wen;
        state_nxt = ARB_NORMAL;
      end
      default: begin
        state_nxt = ARB_NORMAL;
      end
    endcase
  end

  // Starve counter: counts refused LU cycles, saturates, restarts on handshake or idle LU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (lu_hs || !lu_valid) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_CNT_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered write port: LU wins on handshake, else an accepted pipeline write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      W_en   <= 1'b0;
      W_reg  <= '0;
      W_data <= '0;
    end else if (lu_hs) begin
      W_en   <= (lu_wreg != '0);
      W_reg  <= lu_wreg;
      W_data <= lu_wdata;
    end else if (pipe_fire) begin
      W_en   <= 1'b1;
      W_reg  <= pipe_wreg;
      W_data <= pipe_wdata;
    end else begin
      W_en   <= 1'b0;
    end
  end

  reg_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (iss_en),
    .set_reg (iss_reg),
    .clr_en  (lu_hs),
    .clr_reg (lu_wreg),
    .rs1     (rs1),
    .rs2     (rs2),
    .stall   (stall)
  );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_wen;
  logic [4:0]  pipe_wreg;
  logic [31:0] pipe_wdata;
  logic        pipe_hold;
  logic        lu_valid;
  logic [4:0]  lu_wreg;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        iss_en;
  logic [4:0]  iss_reg;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic        W_en;
  logic [4:0]  W_reg;
  logic [31:0] W_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_wen   (pipe_wen),
    .pipe_wreg  (pipe_wreg),
    .pipe_wdata (pipe_wdata),
    .pipe_hold  (pipe_hold),
    .lu_valid   (lu_valid),
    .lu_wreg    (lu_wreg),
    .lu_wdata   (lu_wdata),
    .lu_ready   (lu_ready),
    .iss_en     (iss_en),
    .iss_reg    (iss_reg),
    .rs1        (rs1),
    .rs2        (rs2),
    .stall      (stall),
    .W_en       (W_en),
    .W_reg      (W_reg),
    .W_data     (W_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; pipe_wen = 1'b0; pipe_wreg = '0; pipe_wdata = '0;
    lu_valid = 1'b0; lu_wreg = '0; lu_wdata = '0;
    iss_en = 1'b0; iss_reg = '0; rs1 = '0; rs2 = '0;

    // Reset state
    #2;
    chk("rst_W_en", W_en, 0);
    chk("rst_W_reg", W_reg, 0);
    chk("rst_W_data", W_data, 0);
    chk("rst_lu_ready", lu_ready, 1);
    chk("rst_pipe_hold", pipe_hold, 0);
    chk("rst_stall", stall, 0);
    pipe_wen = 1'b1; pipe_wreg = 5'd1;
    #1;
    chk("rst_lu_ready_pipe", lu_ready, 0);
    pipe_wen = 1'b0; pipe_wreg = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_W_en", W_en, 0);

    // Pipe write only
    pipe_wen = 1'b1; pipe_wreg = 5'd5; pipe_wdata = 32'h1234;
    #1;
    chk("pipe_lu_ready", lu_ready, 0);
    chk("pipe_hold_normal", pipe_hold, 0);
    tick();
    chk("pipe_W_en", W_en, 1);
    chk("pipe_W_reg", W_reg, 5);
    chk("pipe_W_data", W_data, 32'h1234);
    pipe_wen = 1'b0;
    tick();
    chk("idle_W_en", W_en, 0);

    // Contention: four refused cycles, FORCE on the fifth
    pipe_wen = 1'b1; pipe_wreg = 5'd6; pipe_wdata = 32'h55;
    lu_valid = 1'b1; lu_wreg = 5'd7; lu_wdata = 32'hAA;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont_lu_ready_%0d", i), lu_ready, 0);
      chk($sformatf("cont_pipe_hold_%0d", i), pipe_hold, 0);
      tick();
      chk($sformatf("cont_W_reg_%0d", i), W_reg, 6);
    end
    #1;
    chk("force_lu_ready", lu_ready, 1);
    chk("force_pipe_hold", pipe_hold, 1);
    tick();
    chk("force_W_en", W_en, 1);
    chk("force_W_reg", W_reg, 7);
    chk("force_W_data", W_data, 32'hAA);
    lu_valid = 1'b0;
    #1;
    chk("back_normal_lu_ready", lu_ready, 0);
    chk("back_normal_pipe_hold", pipe_hold, 0);
    tick();
    chk("back_normal_W_reg", W_reg, 6);
    pipe_wen = 1'b0;
    tick();

    // Scoreboard RAW stall until LU writeback, no same-cycle bypass
    iss_en = 1'b1; iss_reg = 5'd9;
    #1;
    chk("sb_issue_stall", stall, 0);
    tick();
    iss_en = 1'b0; rs1 = 5'd9;
    #1;
    chk("sb_raw_stall", stall, 1);
    tick();
    chk("sb_raw_stall_hold", stall, 1);
    lu_valid = 1'b1; lu_wreg = 5'd9; lu_wdata = 32'h99;
    #1;
    chk("sb_hs_lu_ready", lu_ready, 1);
    chk("sb_no_bypass", stall, 1);
    tick();
    chk("sb_hs_W_en", W_en, 1);
    chk("sb_hs_W_reg", W_reg, 9);
    chk("sb_hs_W_data", W_data, 32'h99);
    lu_valid = 1'b0;
    #1;
    chk("sb_released", stall, 0);

    // WAW: issuing to a busy register stalls
    rs1 = '0; iss_en = 1'b1; iss_reg = 5'd12;
    tick();
    #1;
    chk("sb_waw_stall", stall, 1);
    iss_en = 1'b0; lu_valid = 1'b1; lu_wreg = 5'd12;
    tick();
    lu_valid = 1'b0; rs1 = 5'd12;
    #1;
    chk("sb_waw_cleared", stall, 0);
    rs1 = '0;

    // Same-cycle set and clear on reg 3: set wins
    iss_en = 1'b1; iss_reg = 5'd3; lu_valid = 1'b1; lu_wreg = 5'd3; lu_wdata = 32'h33;
    #1;
    chk("setclr_lu_ready", lu_ready, 1);
    chk("setclr_stall", stall, 0);
    tick();
    chk("setclr_W_reg", W_reg, 3);
    iss_en = 1'b0; lu_valid = 1'b0; rs2 = 5'd3;
    #1;
    chk("setclr_busy3", stall, 1);
    lu_valid = 1'b1;
    tick();
    lu_valid = 1'b0;
    #1;
    chk("setclr_busy3_cleared", stall, 0);
    rs2 = '0;

    // Register 0: LU to r0 handshakes without a write; pipe to r0 is no request
    lu_valid = 1'b1; lu_wreg = 5'd0; lu_wdata = 32'hDEAD;
    pipe_wen = 1'b1; pipe_wreg = 5'd0; pipe_wdata = 32'h77;
    iss_en = 1'b1; iss_reg = 5'd0;
    #1;
    chk("r0_lu_ready", lu_ready, 1);
    chk("r0_pipe_hold", pipe_hold, 0);
    chk("r0_iss_stall", stall, 0);
    tick();
    chk("r0_W_en", W_en, 0);
    lu_valid = 1'b0; pipe_wen = 1'b0; iss_en = 1'b0;
    tick();

    // Counter clears when LU goes idle, then reset while in FORCE with busy[4]
    iss_en = 1'b1; iss_reg = 5'd4;
    tick();
    iss_en = 1'b0; rs1 = 5'd4;
    #1;
    chk("r4_busy", stall, 1);
    pipe_wen = 1'b1; pipe_wreg = 5'd6; pipe_wdata = 32'h66;
    lu_valid = 1'b1; lu_wreg = 5'd8; lu_wdata = 32'h88;
    tick();
    tick();
    lu_valid = 1'b0;
    tick();
    lu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("clr_cnt_lu_ready_%0d", i), lu_ready, 0);
      chk($sformatf("clr_cnt_pipe_hold_%0d", i), pipe_hold, 0);
      tick();
    end
    #1;
    chk("force2_pipe_hold", pipe_hold, 1);
    chk("force2_W_en_before_rst", W_en, 1);
    reset = 1'b0;
    #1;
    chk("rst_force_W_en", W_en, 0);
    chk("rst_force_W_data", W_data, 0);
    chk("rst_force_pipe_hold", pipe_hold, 0);
    chk("rst_force_lu_ready", lu_ready, 0);
    pipe_wen = 1'b0; lu_valid = 1'b0;
    #1;
    chk("rst_force_stall", stall, 0);
    chk("rst_force_lu_ready_idle", lu_ready, 1);
    tick();
    reset = 1'b1;
    #1;
    chk("rel_stall", stall, 0);
    chk("rel_lu_ready", lu_ready, 1);
    chk("rel_pipe_hold", pipe_hold, 0);
    tick();
    chk("rel_W_en", W_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
